// File: rtl/digit_entry_pkg.sv
// Shared key codes and FSM state encodings for the two-digit minute-entry controller.
package digit_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ONE  = 3'd1,
    ST_TWO  = 3'd2,
    ST_CLR1 = 3'd3,
    ST_CLR2 = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Keypad strobe, shift-register feedback/control and result signals of the entry controller.
interface digit_entry_ctrl_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] ten_in;
  logic [3:0] one_in;
  logic [3:0] sr_din;
  logic       sr_ce;
  logic [6:0] value;
  logic       value_valid;
  logic       err;
  logic       busy;
  logic [1:0] digit_cnt;

  modport master (
    output key_valid, key_code, ten_in, one_in,
    input  sr_din, sr_ce, value, value_valid, err, busy, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, ten_in, one_in,
    output sr_din, sr_ce, value, value_valid, err, busy, digit_cnt
  );

endinterface

// File: rtl/bcd2bin_2digit.sv
// Combinational tens*10+ones conversion, wrapping in 7 bits for out-of-range digit inputs.
module bcd2bin_2digit (
  input  logic [3:0] i_ten,
  input  logic [3:0] i_one,
  output logic [6:0] o_bin
);

  logic [6:0] w_ten_x10;

  assign w_ten_x10 = {3'b000, i_ten} * 7'd10;
  assign o_bin     = w_ten_x10 + {3'b000, i_one};

endmodule

// File: rtl/digit_entry_ctrl.sv
// Keypad FSM that fills an external two-digit BCD shift register, validates ENTER
// against MAX_MIN and clears the register with two zero shifts afterwards.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int MAX_MIN = 90
) (
  input logic          i_clk,
  input logic          i_rst_n,
  digit_entry_ctrl_if.slave io_if
);

  localparam logic [6:0] LP_MAX = 7'(MAX_MIN);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_value;
  logic       r_value_valid;
  logic       r_err;

  logic [6:0] w_bin;
  logic       w_sr_ce;
  logic [3:0] w_sr_din;
  logic       w_err_d;
  logic       w_valid_d;
  logic       w_load;
  logic       w_busy;
  logic [1:0] w_digit_cnt;

  bcd2bin_2digit u_bcd2bin (
    .i_ten (io_if.ten_in),
    .i_one (io_if.one_in),
    .o_bin (w_bin)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Shift controls are combinational so a digit lands in the register on the strobe edge;
  // reset gates them off so the shared register sees no shift while RST is low.
  always_comb begin
    w_next    = r_state;
    w_sr_ce   = 1'b0;
    w_sr_din  = 4'd0;
    w_err_d   = 1'b0;
    w_valid_d = 1'b0;
    w_load    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE, ST_ONE, ST_TWO: begin
          if (io_if.key_valid) begin
            if (is_digit(io_if.key_code)) begin
              if (r_state == ST_TWO) begin
                w_err_d = 1'b1;
              end else begin
                w_sr_ce  = 1'b1;
                w_sr_din = io_if.key_code;
                w_next   = (r_state == ST_IDLE) ? ST_ONE : ST_TWO;
              end
            end else if (io_if.key_code == KEY_CLEAR) begin
              w_next = ST_CLR1;
            end else if (io_if.key_code == KEY_ENTER) begin
              if (r_state != ST_IDLE && w_bin != 7'd0 && w_bin <= LP_MAX) begin
                w_valid_d = 1'b1;
                w_load    = 1'b1;
                w_next    = ST_CLR1;
              end else begin
                w_err_d = 1'b1;
              end
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        ST_CLR1: begin
          w_sr_ce = 1'b1;
          w_next  = ST_CLR2;
        end
        ST_CLR2: begin
          w_sr_ce = 1'b1;
          w_next  = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value       <= 7'd0;
      r_value_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_value_valid <= w_valid_d;
      r_err         <= w_err_d;
      if (w_load) begin
        r_value <= w_bin;
      end
    end
  end

  always_comb begin
    w_busy      = 1'b0;
    w_digit_cnt = 2'd0;
    case (r_state)
      ST_ONE:           w_digit_cnt = 2'd1;
      ST_TWO:           w_digit_cnt = 2'd2;
      ST_CLR1, ST_CLR2: w_busy      = 1'b1;
      default:          w_digit_cnt = 2'd0;
    endcase
  end

  assign io_if.sr_ce       = w_sr_ce;
  assign io_if.sr_din      = w_sr_din;
  assign io_if.value       = r_value;
  assign io_if.value_valid = r_value_valid;
  assign io_if.err         = r_err;
  assign io_if.busy        = w_busy;
  assign io_if.digit_cnt   = w_digit_cnt;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl with a behavioural two-digit shift register on the feedback path.
module tb_digit_entry_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic sCe;
  logic [3:0] sDin;
  logic [3:0] regTen;
  logic [3:0] regOne;

  digit_entry_ctrl_if bus ();

  digit_entry_ctrl #(.MAX_MIN(90)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_if   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External shift register sharing the controller's reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regTen <= 4'd0;
      regOne <= 4'd0;
    end else if (bus.sr_ce) begin
      regTen <= regOne;
      regOne <= bus.sr_din;
    end
  end

  assign bus.ten_in = regTen;
  assign bus.one_in = regOne;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drives one cycle of key input, samples the combinational
  // shift controls, and returns at the next falling edge with registered outputs settled.
  task automatic applyStimulus(input logic kv, input logic [3:0] code);
    bus.key_valid = kv;
    bus.key_code  = code;
    #1;
    sCe  = bus.sr_ce;
    sDin = bus.sr_din;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    #2;
    checkOutput("rst_value", bus.value, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_cnt", bus.digit_cnt, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_vv", bus.value_valid, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // 4,5,ENTER -> 45 then two clear cycles
    applyStimulus(1'b1, 4'd4);
    checkOutput("k4_ce", sCe, 1);
    checkOutput("k4_din", sDin, 4);
    checkOutput("k4_cnt", bus.digit_cnt, 1);
    applyStimulus(1'b1, 4'd5);
    checkOutput("k5_ce", sCe, 1);
    checkOutput("k5_din", sDin, 5);
    checkOutput("k5_cnt", bus.digit_cnt, 2);
    checkOutput("k5_reg", regTen * 10 + regOne, 45);
    applyStimulus(1'b1, 4'hB);
    checkOutput("ent45_ce", sCe, 0);
    checkOutput("ent45_vv", bus.value_valid, 1);
    checkOutput("ent45_val", bus.value, 45);
    checkOutput("ent45_busy", bus.busy, 1);
    checkOutput("ent45_cnt", bus.digit_cnt, 0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("clr1_ce", sCe, 1);
    checkOutput("clr1_din", sDin, 0);
    checkOutput("clr2_vv", bus.value_valid, 0);
    checkOutput("clr2_busy", bus.busy, 1);
    applyStimulus(1'b0, 4'd0);
    checkOutput("clr2_ce", sCe, 1);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_reg", regTen * 10 + regOne, 0);
    checkOutput("idle_cnt", bus.digit_cnt, 0);

    // 9,5,ENTER -> 95 exceeds 90, then CLEAR
    applyStimulus(1'b1, 4'd9);
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b1, 4'hB);
    checkOutput("e95_err", bus.err, 1);
    checkOutput("e95_vv", bus.value_valid, 0);
    checkOutput("e95_val", bus.value, 45);
    checkOutput("e95_cnt", bus.digit_cnt, 2);
    applyStimulus(1'b0, 4'd0);
    checkOutput("e95_err_once", bus.err, 0);
    checkOutput("e95_reg", regTen * 10 + regOne, 95);
    applyStimulus(1'b1, 4'hA);
    checkOutput("clr_busy", bus.busy, 1);
    applyStimulus(1'b0, 4'd0);
    checkOutput("clrA_ce", sCe, 1);
    applyStimulus(1'b0, 4'd0);
    checkOutput("clrB_ce", sCe, 1);
    checkOutput("clrB_busy", bus.busy, 0);
    checkOutput("clrB_reg", regTen * 10 + regOne, 0);

    // 1,2,3 -> third digit rejected, ENTER -> 12
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd3);
    checkOutput("k3_ce", sCe, 0);
    checkOutput("k3_err", bus.err, 1);
    checkOutput("k3_reg", regTen * 10 + regOne, 12);
    applyStimulus(1'b1, 4'hB);
    checkOutput("e12_vv", bus.value_valid, 1);
    checkOutput("e12_val", bus.value, 12);
    checkOutput("e12_err", bus.err, 0);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("e12_idle", bus.busy, 0);

    // ENTER in IDLE, invalid 4'hE, 0 then ENTER
    applyStimulus(1'b1, 4'hB);
    checkOutput("eidle_err", bus.err, 1);
    checkOutput("eidle_cnt", bus.digit_cnt, 0);
    applyStimulus(1'b1, 4'hE);
    checkOutput("inv_err", bus.err, 1);
    checkOutput("inv_ce", sCe, 0);
    applyStimulus(1'b1, 4'd0);
    checkOutput("k0_err", bus.err, 0);
    checkOutput("k0_cnt", bus.digit_cnt, 1);
    applyStimulus(1'b1, 4'hB);
    checkOutput("e0_err", bus.err, 1);
    checkOutput("e0_vv", bus.value_valid, 0);
    checkOutput("e0_val", bus.value, 12);
    checkOutput("e0_cnt", bus.digit_cnt, 1);
    applyStimulus(1'b1, 4'hA);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);

    // 7, CLEAR, key 3 during CLR1 is ignored
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'hA);
    checkOutput("c7_busy", bus.busy, 1);
    applyStimulus(1'b1, 4'd3);
    checkOutput("ign_din", sDin, 0);
    checkOutput("ign_err", bus.err, 0);
    checkOutput("ign_busy", bus.busy, 1);
    applyStimulus(1'b0, 4'd0);
    checkOutput("ign_reg", regTen * 10 + regOne, 0);
    checkOutput("ign_cnt", bus.digit_cnt, 0);
    checkOutput("ign_idle", bus.busy, 0);

    // Boundary: 90 accepted
    applyStimulus(1'b1, 4'd9);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b1, 4'hB);
    checkOutput("e90_vv", bus.value_valid, 1);
    checkOutput("e90_val", bus.value, 90);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);

    // Reset asserted during CLR1
    applyStimulus(1'b1, 4'd6);
    applyStimulus(1'b1, 4'hA);
    checkOutput("pre_rst_busy", bus.busy, 1);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_ce", bus.sr_ce, 0);
    checkOutput("arst_din", bus.sr_din, 0);
    checkOutput("arst_val", bus.value, 0);
    checkOutput("arst_cnt", bus.digit_cnt, 0);
    checkOutput("arst_reg", regTen * 10 + regOne, 0);
    bus.key_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", bus.busy, 0);
    checkOutput("post_rst_cnt", bus.digit_cnt, 0);
    applyStimulus(1'b1, 4'd8);
    checkOutput("k8_cnt", bus.digit_cnt, 1);
    applyStimulus(1'b1, 4'hB);
    checkOutput("e8_vv", bus.value_valid, 1);
    checkOutput("e8_val", bus.value, 8);
    applyStimulus(1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0);
    checkOutput("e8_val_hold", bus.value, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
